// File: rtl/ps2_direction_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 direction decoder.
// PS2DIR_WASD_EN adds the non-extended W/A/S/D codes as steering keys.
package pacman_input_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_t;

  typedef struct packed {
    logic valid;
    logic is_break;
    dir_t dir;
  } dir_evt_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;

  // Maps a scan code to a direction; valid=0 for codes that do not steer.
  function automatic dir_evt_t sc_decode(
    input logic [7:0] code,
    input logic       ext
  );
    dir_evt_t e;
    e = '0;
    if (ext) begin
      e.valid = 1'b1;
      case (code)
        SC_UP:    e.dir = DIR_UP;
        SC_RIGHT: e.dir = DIR_RIGHT;
        SC_DOWN:  e.dir = DIR_DOWN;
        SC_LEFT:  e.dir = DIR_LEFT;
        default:  e.valid = 1'b0;
      endcase
    end else begin
`ifdef PS2DIR_WASD_EN
      e.valid = 1'b1;
      case (code)
        SC_W:    e.dir = DIR_UP;
        SC_D:    e.dir = DIR_RIGHT;
        SC_S:    e.dir = DIR_DOWN;
        SC_A:    e.dir = DIR_LEFT;
        default: e.valid = 1'b0;
      endcase
`else
      e.valid = 1'b0;
`endif
    end
    return e;
  endfunction

endpackage

// File: rtl/ps2_direction_decoder_if.sv
// Keyboard byte stream in, steering direction out.
// master drives bytes, slave is the decoder.
interface ps2_direction_decoder_if;
  logic       ps2_key_pressed;
  logic [7:0] ps2_key_data;
  logic       upSig;
  logic       rightSig;
  logic       downSig;
  logic       leftSig;
  logic       dir_change;
  logic [3:0] held;

  modport master (
    output ps2_key_pressed, ps2_key_data,
    input  upSig, rightSig, downSig, leftSig,
    input  dir_change, held
  );

  modport slave (
    input  ps2_key_pressed, ps2_key_data,
    output upSig, rightSig, downSig, leftSig,
    output dir_change, held
  );
endinterface

// File: rtl/ps2_direction_decoder_prefix_fsm.sv
// Byte edge detect, E0/F0 prefix tracking and prefix timeout.
// Emits one make/break direction event per resolved byte.
module ps2_prefix_fsm
  import pacman_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_key_data,
  output dir_evt_t   evt
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);

  pfx_state_t    state, nxt;
  logic          pressed_q;
  logic          accept;
  logic [CW-1:0] cnt;
  dir_evt_t      evt_c;

  assign accept = ps2_key_pressed & ~pressed_q;
  assign evt    = accept ? evt_c : '0;

  // Next prefix state and resolved event for the byte on the bus.
  always_comb begin
    nxt   = state;
    evt_c = '0;
    unique case (state)
      ST_IDLE: begin
        if (ps2_key_data == SC_EXT)      nxt = ST_EXT;
        else if (ps2_key_data == SC_BRK) nxt = ST_BRK;
        else evt_c = sc_decode(ps2_key_data, 1'b0);
      end
      ST_EXT: begin
        if (ps2_key_data == SC_BRK)      nxt = ST_EXT_BRK;
        else if (ps2_key_data == SC_EXT) nxt = ST_EXT;
        else begin
          evt_c = sc_decode(ps2_key_data, 1'b1);
          nxt   = ST_IDLE;
        end
      end
      ST_BRK: begin
        evt_c          = sc_decode(ps2_key_data, 1'b0);
        evt_c.is_break = 1'b1;
        nxt            = ST_IDLE;
      end
      ST_EXT_BRK: begin
        evt_c          = sc_decode(ps2_key_data, 1'b1);
        evt_c.is_break = 1'b1;
        nxt            = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State, timeout counter and edge-detect register; a byte beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pressed_q <= 1'b0;
    end else begin
      pressed_q <= ps2_key_pressed;
      if (accept) begin
        state <= nxt;
        cnt   <= '0;
      end else if (state != ST_IDLE) begin
        if (cnt == TO_MAX) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Held-key tracking with last-pressed-wins one-hot steering output.
// PS2DIR_WASD_EN (package) also lets W/A/S/D steer.
module ps2_direction_decoder
  import pacman_input_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                    clock,
  input  logic                    resetn,
  ps2_direction_decoder_if.slave  bus
);

  dir_evt_t   evt;
  logic [3:0] held_q, held_n;
  dir_t       cur_q, cur_n;
  logic       act_q, act_n;
  logic [3:0] oh_q, oh_n;
  logic       chg_q;

  ps2_prefix_fsm #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_pfx (
    .clk             (clock),
    .rst_n           (resetn),
    .ps2_key_pressed (bus.ps2_key_pressed),
    .ps2_key_data    (bus.ps2_key_data),
    .evt             (evt)
  );

  // Apply make/break; on releasing the current key fall back in fixed order.
  always_comb begin
    held_n = held_q;
    cur_n  = cur_q;
    act_n  = act_q;
    if (evt.valid) begin
      if (!evt.is_break) begin
        held_n[evt.dir] = 1'b1;
        cur_n           = evt.dir;
        act_n           = 1'b1;
      end else if (held_q[evt.dir]) begin
        held_n[evt.dir] = 1'b0;
        if (act_q && cur_q == evt.dir) begin
          priority case (1'b1)
            held_n[0]: cur_n = DIR_UP;
            held_n[1]: cur_n = DIR_RIGHT;
            held_n[2]: cur_n = DIR_DOWN;
            held_n[3]: cur_n = DIR_LEFT;
            default:   act_n = 1'b0;
          endcase
        end
      end
    end
    oh_n = act_n ? (4'b0001 << cur_n) : 4'b0000;
  end

  // Register arbitration state, one-hot output and its change pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      held_q <= '0;
      cur_q  <= DIR_UP;
      act_q  <= 1'b0;
      oh_q   <= '0;
      chg_q  <= 1'b0;
    end else begin
      held_q <= held_n;
      cur_q  <= cur_n;
      act_q  <= act_n;
      oh_q   <= oh_n;
      chg_q  <= (oh_n != oh_q);
    end
  end

  assign bus.upSig      = oh_q[0];
  assign bus.rightSig   = oh_q[1];
  assign bus.downSig    = oh_q[2];
  assign bus.leftSig    = oh_q[3];
  assign bus.dir_change = chg_q;
  assign bus.held       = held_q;

endmodule

// File: doc/ps2_direction_decoder.md
# ps2_direction_decoder

Converts the raw PS/2 keyboard byte stream into a debounced, last-pressed-wins one-hot movement direction for the Pacman processor. Sits between the PS2_Interface keyboard controller (consumes its byte/strobe pair) and proc_skeleton, where it drives the upSig/rightSig/downSig/leftSig inputs that the board switches drive today. It tracks make/break codes with E0/F0 prefix handling, so held arrow keys steer continuously and releasing a key falls back to any other key still held.

## Interface
- TIMEOUT_CYCLES, 2_000_000, prefix-state abandon time in clock cycles (40 ms at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1)
- clock  in  1  system clock (50 MHz)
- resetn  in  1  reset; one clock; reset is asynchronous and active-low
- ps2_key_pressed  in  1  byte-ready flag from the keyboard controller; a byte is taken on its rising edge only
- ps2_key_data  in  8  received scan-code byte, valid while ps2_key_pressed is high
- upSig, rightSig, downSig, leftSig  out  1 each  one-hot steering direction; all zero = no key held
- dir_change  out  1  one-cycle pulse when the one-hot output changes
- held  out  4  raw held-key mask {left,down,right,up}

## Operation
- Edge detect: register ps2_key_pressed; accept = pressed & ~pressed_q. Exactly one byte per rising edge; typematic repeats arrive as fresh edges.
- Prefix FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen).
  - IDLE: E0->EXT; F0->BRK; else resolve as plain make.
  - EXT: F0->EXT_BRK; E0->EXT (timeout restarts); else resolve as extended make, ->IDLE.
  - BRK: resolve as plain break, ->IDLE. EXT_BRK: resolve as extended break, ->IDLE.
- Direction codes (extended): 75 up, 74 right, 72 down, 6B left. Unknown codes resolve to no effect, FSM returns to IDLE.
- Make of d: held[d]<=1, cur<=d, active<=1 (latest press wins even if other keys are held).
- Break of d: held[d]<=0. If cur==d: choose first remaining held key in fixed order up, right, down, left; if none, active<=0. Break of a key not held: no effect.
- Outputs: dirSig[d] = active && cur==d. dir_change = registered comparison of the next vs current one-hot output; a repeat make of the current direction gives no pulse.
- Timeout: in any non-IDLE state the counter increments each cycle; at TIMEOUT_CYCLES the FSM returns to IDLE, discarding the prefix. The counter clears on every accepted byte.

## Timing
- Reset values: all direction outputs 0, held 0, dir_change 0, FSM IDLE, counter 0, pressed_q 0.
- Latency: rising edge of ps2_key_pressed sampled in cycle N; held/dirSig/dir_change valid at N+1 (one register stage after edge detect).
- An accepted byte and timeout expiry in the same cycle: the byte is processed in the current state; timeout is ignored.
- resetn asserted mid-sequence (e.g., in EXT_BRK): immediate clear; the next byte is interpreted from IDLE.
- ps2_key_pressed held high across several cycles counts as one byte.

## Configuration
- PS2DIR_WASD_EN: when defined, the non-extended codes 1D (W) up, 23 (D) right, 1B (S) down, 1C (A) left also steer, sharing held bits with the arrow keys (make via either key sets the bit; break via either clears it). When undefined, these codes are treated as unknown and only E0-prefixed arrows steer.

## Structure
- Shared package pacman_input_pkg: direction enum (DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3), scan-code constants (SC_EXT=8'hE0, SC_BRK=8'hF0, arrow and WASD codes), FSM state typedef.
- One sub-module: ps2_prefix_fsm (edge detect, prefix states, timeout), emitting a {valid, is_break, dir} event; the top level holds the held/cur/active arbitration.

## Test plan
- Reset, then bytes E0,75 -> upSig=1 one cycle after the 75 edge, dir_change pulses once, held=4'b0001.
- Hold up, send E0,6B, then E0,F0,6B -> leftSig=1 after the press; on release upSig=1 again with a dir_change pulse each time.
- Send E0,75 three times (typematic) -> upSig stays 1, exactly one dir_change pulse in total.
- Send E0, then idle TIMEOUT_CYCLES (use 100 in the bench), then 75 -> no effect (plain 75 is unknown), outputs stay 0.
- Send E0,F0, then assert resetn=0 mid-stream, release, then E0,74 -> rightSig=1, no stale break is applied.
- With PS2DIR_WASD_EN defined: 1C -> leftSig=1; F0,1C -> all outputs 0. Without the macro: 1C leaves the outputs 0.
